// File: rtl/mopshub_seq_pkg.sv
// Shared types and helpers for the MOPSHUB N-bus init sequencer.
// Holds the phase encoding, FSM state encoding and the default timeout.
package mopshub_seq_pkg;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_POWER   = 2'd1,
        PH_TRIM    = 2'd2,
        PH_SIGN_ON = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT      = 3'd3,
        ST_NEXT      = 3'd4,
        ST_PHASE_END = 3'd5,
        ST_DONE      = 3'd6
    } seq_state_t;

    localparam int TIMEOUT_DEF = 4096;

    // Error counter stops at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/mopshub_seq_timer.sv
// Loadable down-counter used as the per-bus phase_done watchdog.
// Load sets TIMEOUT_CYC-1; expired is high while the count sits at zero.
module mopshub_seq_timer #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_r;

    // Watchdog count: load wins over decrement, decrement floors at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {TW{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (dec && (cnt_r != {TW{1'b0}})) begin
            cnt_r <= cnt_r - TW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == {TW{1'b0}});

endmodule

// File: rtl/mopshub_bus_init_sequencer.sv
// Walks every enabled CAN bus through POWER, optional TRIM and SIGN_ON,
// one start pulse per bus, recording buses that never report phase_done.
module mopshub_bus_init_sequencer
    import mopshub_seq_pkg::*;
#(
    parameter int N_BUS       = 32,
    parameter int CNT_W       = $clog2(N_BUS),
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    parameter int SKIP_FAILED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_init,
    input  logic             osc_auto_trim,
    input  logic [CNT_W-1:0] n_buses,
    input  logic [N_BUS-1:0] bus_mask,
    input  logic             phase_done,
    input  logic             endwait_all,
    output logic [CNT_W-1:0] bus_cnt,
    output logic [1:0]       phase,
    output logic             power_bus_en,
    output logic             start_power,
    output logic             start_trim,
    output logic             start_sign_on,
    output logic             busy,
    output logic             end_init,
    output logic [N_BUS-1:0] timeout_mask,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(N_BUS - 1);

    seq_state_t       state_r,   state_s;
    phase_t           phase_r,   phase_s;
    logic [CNT_W-1:0] bus_cnt_r, bus_cnt_s;
    logic [CNT_W-1:0] n_eff_r,   n_eff_s;
    logic [N_BUS-1:0] tmask_r,   tmask_s;
    logic [7:0]       err_r,     err_s;
    logic             busy_r,    busy_s;
    logic             end_init_r, end_init_s;
    logic             start_power_r, start_trim_r, start_sign_on_r, power_bus_en_r;
    logic             tmr_load_s, tmr_dec_s, tmr_expired_s;
    logic             usable_s, last_s;

    mopshub_seq_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load_s),
        .dec     (tmr_dec_s),
        .expired (tmr_expired_s)
    );

    // Bus qualification for the scan step and end-of-range detection.
    always_comb begin
        usable_s = bus_mask[bus_cnt_r] && !((SKIP_FAILED != 0) && tmask_r[bus_cnt_r]);
        last_s   = (bus_cnt_r == n_eff_r);
    end

    // Next-state logic for the sequencer FSM and its bookkeeping.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        bus_cnt_s  = bus_cnt_r;
        n_eff_s    = n_eff_r;
        tmask_s    = tmask_r;
        err_s      = err_r;
        busy_s     = busy_r;
        end_init_s = 1'b0;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_init) begin
                    state_s   = ST_SCAN;
                    phase_s   = PH_POWER;
                    bus_cnt_s = {CNT_W{1'b0}};
                    busy_s    = 1'b1;
                    tmask_s   = {N_BUS{1'b0}};
                    err_s     = 8'd0;
                    n_eff_s   = (n_buses > MAX_IDX) ? MAX_IDX : n_buses;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (usable_s) begin
                    state_s = ST_ISSUE;
                end else if (last_s) begin
                    state_s = ST_PHASE_END;
                end else begin
                    bus_cnt_s = bus_cnt_r + CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                tmr_load_s = 1'b1;
                state_s    = ST_WAIT;
            end
            ST_WAIT: begin
                // A late answer landing on the expiry cycle still counts as success.
                if (phase_done || endwait_all) begin
                    state_s = ST_NEXT;
                end else if (tmr_expired_s) begin
                    tmask_s[bus_cnt_r] = 1'b1;
                    err_s              = sat_inc8(err_r);
                    state_s            = ST_NEXT;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            ST_NEXT: begin
                if (last_s) begin
                    state_s = ST_PHASE_END;
                end else begin
                    bus_cnt_s = bus_cnt_r + CNT_W'(1);
                    state_s   = ST_SCAN;
                end
            end
            ST_PHASE_END: begin
                bus_cnt_s = {CNT_W{1'b0}};
                state_s   = ST_SCAN;
                case (phase_r)
                    PH_POWER: phase_s = osc_auto_trim ? PH_TRIM : PH_SIGN_ON;
                    PH_TRIM:  phase_s = PH_SIGN_ON;
                    default: begin
                        phase_s    = PH_IDLE;
                        busy_s     = 1'b0;
                        end_init_s = 1'b1;
                        state_s    = ST_DONE;
                    end
                endcase
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = PH_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; start pulses decode the upcoming ISSUE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            phase_r         <= PH_IDLE;
            bus_cnt_r       <= {CNT_W{1'b0}};
            n_eff_r         <= {CNT_W{1'b0}};
            tmask_r         <= {N_BUS{1'b0}};
            err_r           <= 8'd0;
            busy_r          <= 1'b0;
            end_init_r      <= 1'b0;
            start_power_r   <= 1'b0;
            start_trim_r    <= 1'b0;
            start_sign_on_r <= 1'b0;
            power_bus_en_r  <= 1'b0;
        end else begin
            state_r         <= state_s;
            phase_r         <= phase_s;
            bus_cnt_r       <= bus_cnt_s;
            n_eff_r         <= n_eff_s;
            tmask_r         <= tmask_s;
            err_r           <= err_s;
            busy_r          <= busy_s;
            end_init_r      <= end_init_s;
            start_power_r   <= (state_s == ST_ISSUE) && (phase_s == PH_POWER);
            start_trim_r    <= (state_s == ST_ISSUE) && (phase_s == PH_TRIM);
            start_sign_on_r <= (state_s == ST_ISSUE) && (phase_s == PH_SIGN_ON);
            power_bus_en_r  <= (phase_s == PH_POWER);
        end
    end

    assign bus_cnt       = bus_cnt_r;
    assign phase         = phase_r;
    assign power_bus_en  = power_bus_en_r;
    assign start_power   = start_power_r;
    assign start_trim    = start_trim_r;
    assign start_sign_on = start_sign_on_r;
    assign busy          = busy_r;
    assign end_init      = end_init_r;
    assign timeout_mask  = tmask_r;
    assign err_cnt       = err_r;

endmodule

// File: tb/tb_mopshub_bus_init_sequencer.sv
// Directed bench for mopshub_bus_init_sequencer: 16 buses, 16-cycle timeout,
// an in-bench executor answering start pulses with configurable delays.
module tb_mopshub_bus_init_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_init = 1'b0;
    logic        osc_auto_trim = 1'b0;
    logic [3:0]  n_buses = 4'd0;
    logic [15:0] bus_mask = 16'h0000;
    logic        phase_done = 1'b0;
    logic        endwait_all = 1'b0;
    logic [3:0]  bus_cnt;
    logic [1:0]  phase;
    logic        power_bus_en, start_power, start_trim, start_sign_on, busy, end_init;
    logic [15:0] timeout_mask;
    logic [7:0]  err_cnt;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // executor behaviour for the next run
    logic [15:0] cfg_silent_pow;
    int cfg_dly_bus, cfg_dly_val, cfg_ew_bus, cfg_mid_start, cfg_rst_bus;

    // observations of the last run
    logic [15:0] seen_pow, seen_trim, seen_sign;
    int cnt_pow, cnt_trim, cnt_sign, cnt_end, multi_viol, pbe_viol, first_ph, first_bus;
    bit aborted;

    mopshub_bus_init_sequencer #(
        .N_BUS       (16),
        .CNT_W       (4),
        .TIMEOUT_CYC (16),
        .SKIP_FAILED (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_init    (start_init),
        .osc_auto_trim (osc_auto_trim),
        .n_buses       (n_buses),
        .bus_mask      (bus_mask),
        .phase_done    (phase_done),
        .endwait_all   (endwait_all),
        .bus_cnt       (bus_cnt),
        .phase         (phase),
        .power_bus_en  (power_bus_en),
        .start_power   (start_power),
        .start_trim    (start_trim),
        .start_sign_on (start_sign_on),
        .busy          (busy),
        .end_init      (end_init),
        .timeout_mask  (timeout_mask),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_clear();
        cfg_silent_pow = 16'h0000;
        cfg_dly_bus    = -1;
        cfg_dly_val    = 2;
        cfg_ew_bus     = -1;
        cfg_mid_start  = -1;
        cfg_rst_bus    = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"}, 32'(phase), 32'h0);
        check({tag, "_bus_cnt"}, 32'(bus_cnt), 32'h0);
        check({tag, "_ctl"}, 32'({busy, end_init, start_power, start_trim, start_sign_on, power_bus_en}), 32'h0);
        check({tag, "_tmask"}, 32'(timeout_mask), 32'h0);
        check({tag, "_err"}, 32'(err_cnt), 32'h0);
    endtask

    // Starts a sequence and acts as the executor until end_init or the cycle budget.
    task automatic run_seq(input int budget);
        int cd, ew, cur_bus, cur_ph;
        bit fin, first;
        cd = 0; ew = 0; cur_bus = -1; cur_ph = 0; fin = 1'b0; first = 1'b1;
        seen_pow = 16'h0; seen_trim = 16'h0; seen_sign = 16'h0;
        cnt_pow = 0; cnt_trim = 0; cnt_sign = 0; cnt_end = 0;
        multi_viol = 0; pbe_viol = 0; first_ph = 0; first_bus = -1; aborted = 1'b0;
        @(negedge clk);
        start_init = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < budget; cyc++) begin
            start_init = 1'b0; phase_done = 1'b0; endwait_all = 1'b0;
            if (int'(start_power) + int'(start_trim) + int'(start_sign_on) > 1) multi_viol++;
            if (power_bus_en !== (phase == 2'd1)) pbe_viol++;
            if (end_init === 1'b1) begin cnt_end++; fin = 1'b1; end
            if (ew > 0) begin
                ew--;
                if (ew == 0) check("endwait_adv", 32'(bus_cnt), 32'(cfg_ew_bus + 1));
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (cur_ph == 1 && cur_bus == cfg_ew_bus) begin endwait_all = 1'b1; ew = 2; end
                    else phase_done = 1'b1;
                end
            end
            if (cyc == cfg_mid_start) start_init = 1'b1;
            if (start_power || start_trim || start_sign_on) begin
                cur_bus = int'(bus_cnt);
                cur_ph  = start_power ? 1 : (start_trim ? 2 : 3);
                if (first) begin first_ph = cur_ph; first_bus = cur_bus; first = 1'b0; end
                case (cur_ph)
                    1:       begin seen_pow[cur_bus]  = 1'b1; cnt_pow++;  end
                    2:       begin seen_trim[cur_bus] = 1'b1; cnt_trim++; end
                    default: begin seen_sign[cur_bus] = 1'b1; cnt_sign++; end
                endcase
                if (cur_ph == 2 && cur_bus == cfg_rst_bus) begin
                    rst = 1'b1;
                    #1;
                    check("rst_phase", 32'(phase), 32'h0);
                    check("rst_bus_cnt", 32'(bus_cnt), 32'h0);
                    check("rst_ctl", 32'({busy, end_init, start_power, start_trim, start_sign_on, power_bus_en}), 32'h0);
                    #1;
                    rst = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                if (!(cur_ph == 1 && cfg_silent_pow[cur_bus]))
                    cd = (cur_ph == 1 && cur_bus == cfg_dly_bus) ? cfg_dly_val : 2;
            end
            if (fin) break;
            @(negedge clk);
        end
        start_init = 1'b0; phase_done = 1'b0; endwait_all = 1'b0;
        if (!aborted) check("end_seen", 32'(fin), 32'h1);
    endtask

    initial begin
        cfg_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // 1: four buses, no trim, prompt answers
        n_buses = 4'd3; bus_mask = 16'h000F; osc_auto_trim = 1'b0;
        run_seq(600);
        check("t1_pow_mask", 32'(seen_pow), 32'h000F);
        check("t1_pow_cnt", 32'(cnt_pow), 32'd4);
        check("t1_sign_mask", 32'(seen_sign), 32'h000F);
        check("t1_sign_cnt", 32'(cnt_sign), 32'd4);
        check("t1_trim_cnt", 32'(cnt_trim), 32'd0);
        check("t1_end_cnt", 32'(cnt_end), 32'd1);
        check("t1_err", 32'(err_cnt), 32'd0);
        check("t1_one_pulse", 32'(multi_viol), 32'd0);
        check("t1_pwr_en", 32'(pbe_viol), 32'd0);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'h0);

        // 2: sparse mask over 16 buses with trim
        n_buses = 4'd15; bus_mask = 16'h00A5; osc_auto_trim = 1'b1;
        run_seq(1500);
        check("t2_pow_mask", 32'(seen_pow), 32'h00A5);
        check("t2_trim_mask", 32'(seen_trim), 32'h00A5);
        check("t2_sign_mask", 32'(seen_sign), 32'h00A5);
        check("t2_total", 32'(cnt_pow + cnt_trim + cnt_sign), 32'd12);
        check("t2_end_cnt", 32'(cnt_end), 32'd1);
        check("t2_pwr_en", 32'(pbe_viol), 32'd0);

        // 3: bus 2 silent in POWER, skipped afterwards
        n_buses = 4'd3; bus_mask = 16'h000F; osc_auto_trim = 1'b0;
        cfg_silent_pow = 16'h0004;
        run_seq(800);
        check("t3_pow_mask", 32'(seen_pow), 32'h000F);
        check("t3_sign_mask", 32'(seen_sign), 32'h000B);
        check("t3_tmask", 32'(timeout_mask), 32'h0004);
        check("t3_err", 32'(err_cnt), 32'd1);
        cfg_clear();

        // 4: endwait_all on bus 1 instead of phase_done
        n_buses = 4'd2; bus_mask = 16'h0007;
        cfg_ew_bus = 1;
        run_seq(600);
        check("t4_pow_mask", 32'(seen_pow), 32'h0007);
        check("t4_sign_mask", 32'(seen_sign), 32'h0007);
        check("t4_tmask", 32'(timeout_mask), 32'h0000);
        check("t4_err", 32'(err_cnt), 32'd0);
        cfg_clear();

        // 5: answer on the expiry cycle, stray start_init mid-run
        n_buses = 4'd3; bus_mask = 16'h000F;
        cfg_dly_bus = 1; cfg_dly_val = 16; cfg_mid_start = 20;
        run_seq(800);
        check("t5_tmask", 32'(timeout_mask), 32'h0000);
        check("t5_err", 32'(err_cnt), 32'd0);
        check("t5_pow_cnt", 32'(cnt_pow), 32'd4);
        check("t5_sign_cnt", 32'(cnt_sign), 32'd4);
        check("t5_end_cnt", 32'(cnt_end), 32'd1);
        cfg_clear();

        // 6: reset during TRIM of bus 5, then a clean restart
        n_buses = 4'd15; bus_mask = 16'h00A5; osc_auto_trim = 1'b1;
        cfg_rst_bus = 5;
        run_seq(1500);
        check("t6_aborted", 32'(aborted), 32'h1);
        check("t6_trim_mask", 32'(seen_trim), 32'h0025);
        check("t6_no_end", 32'(cnt_end), 32'd0);
        cfg_clear();
        n_buses = 4'd3; bus_mask = 16'h000F; osc_auto_trim = 1'b0;
        run_seq(600);
        check("t6_first_phase", 32'(first_ph), 32'd1);
        check("t6_first_bus", 32'(first_bus), 32'd0);
        check("t6_pow_mask", 32'(seen_pow), 32'h000F);
        check("t6_end_cnt", 32'(cnt_end), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
